// File: rtl/trigger_link_pkg.sv
// trigger_link_pkg: shared framing constants, receiver state encoding and CRC-8 step for the trigger link
package trigger_link_pkg;
  localparam logic [7:0] DEF_SOP = 8'h3C;
  localparam logic [7:0] DEF_EOP = 8'hBC;
  localparam logic [7:0] DEF_TRIGGER_CTRL = 8'h30;
  localparam int FRAME_LEN = 10;
  localparam logic [3:0] IDX_STATUS = 4'd1;
  localparam logic [3:0] IDX_ADDR1 = 4'd2;
  localparam logic [3:0] IDX_ADDR0 = 4'd3;
  localparam logic [3:0] IDX_DATA0 = 4'd4;
  localparam logic [3:0] IDX_CRC = 4'd8;
  localparam logic [3:0] IDX_EOP = 4'd9;
  typedef enum logic [1:0] {HUNT, RECV, EOPCHK} rx_state_t;
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ 8'h07 : {c[6:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/trigger_crc8.sv
// trigger_crc8: byte-serial CRC-8 (poly 0x07, init 0x00) accumulator with clear and enable
module trigger_crc8
  import trigger_link_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);
  always_ff @(posedge clk or posedge reset)
    if (reset) crc <= '0;
    else if (clr) crc <= '0;
    else if (en) crc <= crc8_step(crc, data);
endmodule

// File: rtl/trigger_frame_receiver.sv
// trigger_frame_receiver: hunts SOP, captures a 10-byte trigger frame, validates EOP/CRC and publishes fields
module trigger_frame_receiver
  import trigger_link_pkg::*;
#(
  parameter logic [7:0]  SOP           = DEF_SOP,
  parameter logic [7:0]  EOP           = DEF_EOP,
  parameter logic [7:0]  TRIGGER_CTRL  = DEF_TRIGGER_CTRL,
  parameter bit          CRC_CHECK_EN  = 1'b0,
  parameter int unsigned STALL_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        frame_valid,
  output logic        is_trigger,
  output logic [7:0]  rx_status,
  output logic [15:0] rx_address,
  output logic [31:0] rx_data,
  output logic        frame_error,
  output logic        seq_error,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
);
  localparam logic [15:0] STALL_LAST = 16'(STALL_TIMEOUT - 1);
  rx_state_t state, next_state;
  logic [3:0] idx;
  logic [7:0] sh_status, sh_crc, crc, prev_status;
  logic [15:0] sh_addr, stall_cnt;
  logic [31:0] sh_data;
  logic [4:0] dsel;
  logic prev_valid, cap, sop_hit, eop_ok, good, bad_eop, stall_to, crc_clr, crc_en, trig, seq_gap;
  trigger_crc8 u_crc (
    .clk  (clk),
    .reset(reset),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (data_in),
    .crc  (crc)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HUNT;
    else state <= next_state;
  always_comb begin
    next_state = stall_to ? HUNT :
                 state == HUNT ? (sop_hit ? RECV : HUNT) :
                 !data_valid ? state :
                 state == RECV ? (idx == IDX_CRC ? EOPCHK : RECV) :
                 crc_clr ? RECV : HUNT;
  end
  // a bad closing byte that is itself SOP opens the next frame immediately
  always_comb begin
    cap      = state == RECV && data_valid;
    sop_hit  = state == HUNT && data_valid && data_in == SOP;
    eop_ok   = data_in == EOP && (!CRC_CHECK_EN || sh_crc == crc);
    good     = state == EOPCHK && data_valid && eop_ok;
    bad_eop  = state == EOPCHK && data_valid && !eop_ok;
    stall_to = state != HUNT && !data_valid && stall_cnt == STALL_LAST;
    crc_clr  = sop_hit || (bad_eop && data_in == SOP);
    crc_en   = cap && idx < IDX_CRC;
    trig     = sh_addr[15:8] == TRIGGER_CTRL;
    seq_gap  = prev_valid && sh_status != 8'h00 && sh_status != prev_status + 8'd1;
    dsel     = {2'd3 - idx[1:0], 3'b000};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx         <= '0;
      stall_cnt   <= '0;
      sh_status   <= '0;
      sh_addr     <= '0;
      sh_data     <= '0;
      sh_crc      <= '0;
      prev_status <= '0;
      prev_valid  <= 1'b0;
      frame_valid <= 1'b0;
      is_trigger  <= 1'b0;
      frame_error <= 1'b0;
      seq_error   <= 1'b0;
      rx_status   <= '0;
      rx_address  <= '0;
      rx_data     <= '0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      idx         <= crc_clr ? IDX_STATUS : cap ? idx + 4'd1 : next_state == HUNT ? 4'd0 : idx;
      stall_cnt   <= (state == HUNT || data_valid || stall_to) ? 16'd0 : stall_cnt + 16'd1;
      frame_valid <= good;
      is_trigger  <= good && trig;
      seq_error   <= good && trig && seq_gap;
      frame_error <= bad_eop || stall_to;
      if (cap && idx == IDX_STATUS) sh_status <= data_in;
      if (cap && idx == IDX_ADDR1) sh_addr[15:8] <= data_in;
      if (cap && idx == IDX_ADDR0) sh_addr[7:0] <= data_in;
      if (cap && idx >= IDX_DATA0 && idx < IDX_CRC) sh_data[dsel +: 8] <= data_in;
      if (cap && idx == IDX_CRC) sh_crc <= data_in;
      if (good) begin
        rx_status   <= sh_status;
        rx_address  <= sh_addr;
        rx_data     <= sh_data;
        frame_count <= frame_count + {15'd0, frame_count != 16'hFFFF};
      end
      if (good && trig) begin
        prev_status <= sh_status;
        prev_valid  <= 1'b1;
      end
      if (bad_eop || stall_to) error_count <= error_count + {15'd0, error_count != 16'hFFFF};
    end
endmodule
